// File: rtl/smask_pkg.sv
// Shared types and constants for the shadow-mask table loader.
package smask_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_MAGIC, S_DIM, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [15:0] SMASK_MAGIC   = 16'h4D53;
  localparam logic [1:0]  ERR_NONE      = 2'd0;
  localparam logic [1:0]  ERR_MAGIC     = 2'd1;
  localparam logic [1:0]  ERR_ADDR      = 2'd2;
  localparam logic [1:0]  ERR_CSUM      = 2'd3;
  localparam logic [11:0] SMASK_NEUTRAL = 12'hFFF;

  function automatic logic is_parsing(input state_t s);
    return (s == S_MAGIC) || (s == S_DIM) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/smask_loader_if.sv
// I/O controller download stream, vblank, mixer read port and loader status.
interface smask_loader_if #(
  parameter int DW = 16,
  parameter int EW = 12
);
  logic [15:0]   ioctl_index;
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [27:0]   ioctl_addr;
  logic [DW-1:0] ioctl_data;
  logic          vb;
  logic [3:0]    rd_x;
  logic [3:0]    rd_y;
  logic [EW-1:0] rd_data;
  logic          mask_valid;
  logic [3:0]    active_w;
  logic [3:0]    active_h;
  logic          busy;
  logic          load_err;
  logic [1:0]    err_code;

  modport master (
    output ioctl_index, ioctl_download, ioctl_wr, ioctl_addr, ioctl_data,
    output vb, rd_x, rd_y,
    input  rd_data, mask_valid, active_w, active_h, busy, load_err, err_code
  );

  modport slave (
    input  ioctl_index, ioctl_download, ioctl_wr, ioctl_addr, ioctl_data,
    input  vb, rd_x, rd_y,
    output rd_data, mask_valid, active_w, active_h, busy, load_err, err_code
  );
endinterface

// File: rtl/smask_dpram.sv
// Two banks of 256 mask entries; bank select is the address MSB. Registered read.
module smask_dpram #(
  parameter int EW = 12,
  parameter int AW = 9
)(
  input  logic          clk_sys,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);
  logic [EW-1:0] mem [2**AW];

  always_ff @(posedge clk_sys) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/smask_loader.sv
// Parses a shadow-mask download into the inactive RAM bank and swaps banks at
// the next vblank rising edge, so the mixer only ever reads a complete mask.
module smask_loader
  import smask_pkg::*;
#(
  parameter int          DW        = 16,
  parameter logic [15:0] SMASK_IDX = 16'd3,
  parameter int          EW        = 12,
  parameter logic [15:0] MAGIC     = SMASK_MAGIC
)(
  input logic      clk_sys,
  input logic      reset,
  smask_loader_if.slave bus
);

  logic [DW-1:0] word;
  logic mask_dl, mask_dl_q, vb_q;
  logic dl_rise, dl_fall, vb_rise, wr_acc, commit;

  assign word    = bus.ioctl_data;
  assign mask_dl = bus.ioctl_download && (bus.ioctl_index == SMASK_IDX);
  assign dl_rise = mask_dl && !mask_dl_q;
  assign dl_fall = !mask_dl && mask_dl_q;
  assign vb_rise = bus.vb && !vb_q;
  assign wr_acc  = bus.ioctl_wr && mask_dl;

  state_t      state, state_nx, cur;
  logic [8:0]  n, n_nx, n_cur;
  logic [3:0]  x, y, w_m1, h_m1, x_nx, y_nx, w_nx, h_nx;
  logic [15:0] csum, csum_nx;
  logic [1:0]  err, err_nx;
  logic        load_err, load_err_nx, pending, pending_nx;
  logic        bank, mask_valid, oob_q;
  logic [3:0]  act_w, act_h;
  logic        ram_we;
  logic [EW-1:0] ram_q;

  // A new download takes effect in the cycle it starts, so a word that
  // arrives on that same cycle is parsed as the magic word.
  always_comb begin
    state_nx    = state;
    n_nx        = n;
    x_nx        = x;
    y_nx        = y;
    w_nx        = w_m1;
    h_nx        = h_m1;
    csum_nx     = csum;
    err_nx      = err;
    load_err_nx = load_err;
    pending_nx  = pending;
    ram_we      = 1'b0;
    cur         = state;
    n_cur       = n;
    commit      = vb_rise && pending && !dl_rise;

    if (dl_rise) begin
      cur         = S_MAGIC;
      n_cur       = '0;
      state_nx    = S_MAGIC;
      n_nx        = '0;
      err_nx      = ERR_NONE;
      load_err_nx = 1'b0;
      pending_nx  = 1'b0;
    end
    if (commit) pending_nx = 1'b0;

    if (is_parsing(cur) && dl_fall) begin
      err_nx   = ERR_ADDR;
      state_nx = S_ERROR;
    end else if (is_parsing(cur) && wr_acc) begin
      n_nx = n_cur + 9'd1;
      if (bus.ioctl_addr != 28'({n_cur, 1'b0})) begin
        err_nx   = ERR_ADDR;
        state_nx = S_ERROR;
      end else begin
        case (cur)
          S_MAGIC: begin
            if (word == MAGIC) state_nx = S_DIM;
            else begin
              err_nx   = ERR_MAGIC;
              state_nx = S_ERROR;
            end
          end
          S_DIM: begin
            w_nx     = word[7:4];
            h_nx     = word[3:0];
            x_nx     = '0;
            y_nx     = '0;
            csum_nx  = '0;
            state_nx = S_DATA;
          end
          S_DATA: begin
            ram_we  = 1'b1;
            csum_nx = csum + word;
            if (x == w_m1) begin
              x_nx = '0;
              if (y == h_m1) state_nx = S_CSUM;
              else           y_nx = y + 4'd1;
            end else begin
              x_nx = x + 4'd1;
            end
          end
          S_CSUM: begin
            if (word == csum) begin
              pending_nx = 1'b1;
              state_nx   = S_DONE;
            end else begin
              err_nx   = ERR_CSUM;
              state_nx = S_ERROR;
            end
          end
          default: ;
        endcase
      end
    end

    if (cur == S_ERROR) begin
      load_err_nx = 1'b1;
      state_nx    = S_IDLE;
    end
    if (cur == S_DONE && commit) state_nx = S_IDLE;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      n          <= '0;
      x          <= '0;
      y          <= '0;
      w_m1       <= '0;
      h_m1       <= '0;
      csum       <= '0;
      err        <= ERR_NONE;
      load_err   <= 1'b0;
      pending    <= 1'b0;
      bank       <= 1'b0;
      mask_valid <= 1'b0;
      act_w      <= '0;
      act_h      <= '0;
      mask_dl_q  <= 1'b0;
      vb_q       <= 1'b0;
      oob_q      <= 1'b1;
    end else begin
      state     <= state_nx;
      n         <= n_nx;
      x         <= x_nx;
      y         <= y_nx;
      w_m1      <= w_nx;
      h_m1      <= h_nx;
      csum      <= csum_nx;
      err       <= err_nx;
      load_err  <= load_err_nx;
      pending   <= pending_nx;
      mask_dl_q <= mask_dl;
      vb_q      <= bus.vb;
      if (commit) begin
        bank       <= !bank;
        act_w      <= w_m1;
        act_h      <= h_m1;
        mask_valid <= 1'b1;
      end
      // Range check is registered alongside the RAM read to keep them aligned.
      oob_q <= !mask_valid || (bus.rd_x > act_w) || (bus.rd_y > act_h);
    end
  end

  smask_dpram #(.EW(EW), .AW(9)) u_ram (
    .clk_sys (clk_sys),
    .we      (ram_we),
    .waddr   ({!bank, y, x}),
    .wdata   (word[EW-1:0]),
    .raddr   ({bank, bus.rd_y, bus.rd_x}),
    .rdata   (ram_q)
  );

  assign bus.rd_data    = oob_q ? SMASK_NEUTRAL : ram_q;
  assign bus.mask_valid = mask_valid;
  assign bus.active_w   = act_w;
  assign bus.active_h   = act_h;
  assign bus.busy       = is_parsing(state) || pending;
  assign bus.load_err   = load_err;
  assign bus.err_code   = err;

endmodule

// File: tb/tb_smask_loader.sv
// Directed bench for smask_loader: loads, error paths, vblank commit timing.
module tb_smask_loader;
  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  smask_loader_if #(.DW(16), .EW(12)) bus();

  smask_loader #(.DW(16), .SMASK_IDX(16'd3), .EW(12), .MAGIC(16'h4D53)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] q[$];
  logic [11:0] sh[256];
  logic [11:0] cm[256];
  logic [3:0]  cw, ch;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_word(input logic [27:0] a, input logic [15:0] d);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_data = d;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  // Entry words carry junk in [15:12]; the checksum covers the full word.
  task automatic build(input logic [3:0] wm1, input logic [3:0] hm1,
                       input logic [11:0] seed, input logic [15:0] cdelta);
    logic [15:0] s;
    logic [15:0] e;
    s = 16'd0;
    q.delete();
    q.push_back(16'h4D53);
    q.push_back({8'hC3, wm1, hm1});
    for (int yy = 0; yy <= int'(hm1); yy++)
      for (int xx = 0; xx <= int'(wm1); xx++) begin
        e = {4'hA, seed + 12'(yy * 37 + xx * 5)};
        sh[{yy[3:0], xx[3:0]}] = e[11:0];
        q.push_back(e);
        s = s + e;
      end
    q.push_back(s + cdelta);
  endtask

  task automatic send_q(input int gap_at, input bit vb_on_last, input bit started);
    if (!started) begin
      bus.ioctl_index    = 16'd3;
      bus.ioctl_download = 1'b1;
      tick();
    end
    for (int i = 0; i < q.size(); i++) begin
      if (vb_on_last && i == q.size() - 1) bus.vb = 1'b1;
      wr_word(28'(2 * i + ((gap_at >= 0 && i >= gap_at) ? 2 : 0)), q[i]);
    end
    bus.ioctl_download = 1'b0;
    tick();
  endtask

  task automatic vb_pulse();
    bus.vb = 1'b1;
    tick();
    bus.vb = 1'b0;
    tick();
  endtask

  task automatic take_commit(input logic [3:0] wm1, input logic [3:0] hm1);
    cm = sh;
    cw = wm1;
    ch = hm1;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] rx, input logic [3:0] ry,
                        input logic [11:0] exp);
    bus.rd_x = rx;
    bus.rd_y = ry;
    tick();
    chk(tag, bus.rd_data, exp);
  endtask

  task automatic chk_active(input string tag);
    chk({tag, " valid"}, bus.mask_valid, 1'b1);
    chk({tag, " w"}, bus.active_w, cw);
    chk({tag, " h"}, bus.active_h, ch);
    for (int yy = 0; yy <= int'(ch); yy++)
      for (int xx = 0; xx <= int'(cw); xx++)
        rd_chk({tag, " rd"}, xx[3:0], yy[3:0], cm[{yy[3:0], xx[3:0]}]);
    if (cw != 4'hF) rd_chk({tag, " rd x oob"}, cw + 4'd1, 4'd0, 12'hFFF);
    if (ch != 4'hF) rd_chk({tag, " rd y oob"}, 4'd0, ch + 4'd1, 12'hFFF);
  endtask

  initial begin
    reset              = 1'b1;
    bus.ioctl_index    = 16'd0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = 28'd0;
    bus.ioctl_data     = 16'd0;
    bus.vb             = 1'b0;
    bus.rd_x           = 4'd0;
    bus.rd_y           = 4'd0;
    tick();
    tick();
    chk("rst mask_valid", bus.mask_valid, 1'b0);
    chk("rst active_w", bus.active_w, 4'd0);
    chk("rst active_h", bus.active_h, 4'd0);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst load_err", bus.load_err, 1'b0);
    chk("rst err_code", bus.err_code, 2'd0);
    chk("rst rd_data", bus.rd_data, 12'hFFF);
    reset = 1'b0;
    tick();

    // Bad magic
    bus.ioctl_index    = 16'd3;
    bus.ioctl_download = 1'b1;
    tick();
    chk("magic busy during", bus.busy, 1'b1);
    wr_word(28'd0, 16'h1234);
    bus.ioctl_download = 1'b0;
    tick();
    chk("magic load_err", bus.load_err, 1'b1);
    chk("magic err_code", bus.err_code, 2'd1);
    chk("magic mask_valid", bus.mask_valid, 1'b0);
    chk("magic busy", bus.busy, 1'b0);

    // 2x2 directed load, checksum 0F00+00F0+000F+0FFF = 1FFE
    q = '{16'h4D53, 16'h0011, 16'h0F00, 16'h00F0, 16'h000F, 16'h0FFF, 16'h1FFE};
    send_q(-1, 1'b0, 1'b0);
    chk("2x2 load_err cleared", bus.load_err, 1'b0);
    chk("2x2 err_code cleared", bus.err_code, 2'd0);
    chk("2x2 busy pending", bus.busy, 1'b1);
    chk("2x2 not yet valid", bus.mask_valid, 1'b0);
    vb_pulse();
    chk("2x2 busy after commit", bus.busy, 1'b0);
    rd_chk("2x2 rd(1,0)", 4'd1, 4'd0, 12'h0F0);
    rd_chk("2x2 rd(2,0)", 4'd2, 4'd0, 12'hFFF);
    sh[8'h00] = 12'hF00; sh[8'h01] = 12'h0F0; sh[8'h10] = 12'h00F; sh[8'h11] = 12'hFFF;
    take_commit(4'd1, 4'd1);
    chk_active("2x2");

    // Checksum off by one
    build(4'd2, 4'd1, 12'h123, 16'd1);
    send_q(-1, 1'b0, 1'b0);
    chk("csum err_code", bus.err_code, 2'd3);
    chk("csum load_err", bus.load_err, 1'b1);
    chk("csum busy", bus.busy, 1'b0);
    vb_pulse();
    chk_active("csum keep");

    // Address gap: word at addr 6 after addr 2
    build(4'd1, 4'd1, 12'h222, 16'd0);
    send_q(2, 1'b0, 1'b0);
    chk("gap err_code", bus.err_code, 2'd2);
    chk("gap load_err", bus.load_err, 1'b1);
    vb_pulse();
    chk_active("gap keep");

    // Download dropped mid-DATA
    build(4'd1, 4'd1, 12'h333, 16'd0);
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) wr_word(28'(2 * i), q[i]);
    bus.ioctl_download = 1'b0;
    tick();
    tick();
    chk("abort err_code", bus.err_code, 2'd2);
    chk("abort load_err", bus.load_err, 1'b1);
    vb_pulse();
    vb_pulse();
    chk_active("abort keep");

    // Completion while vb held high: commit only on the next rise
    bus.vb = 1'b1;
    tick();
    build(4'd0, 4'd0, 12'h4BC, 16'd0);
    send_q(-1, 1'b0, 1'b0);
    tick();
    chk("vbhigh no commit w", bus.active_w, 4'd1);
    chk("vbhigh busy", bus.busy, 1'b1);
    bus.vb = 1'b0;
    tick();
    chk("vbfall no commit w", bus.active_w, 4'd1);
    bus.vb = 1'b1;
    tick();
    bus.vb = 1'b0;
    take_commit(4'd0, 4'd0);
    chk_active("vbhigh");

    // Completion on the same cycle as a vb rise
    build(4'd1, 4'd0, 12'h456, 16'd0);
    send_q(-1, 1'b1, 1'b0);
    chk("same-edge no commit w", bus.active_w, 4'd0);
    chk("same-edge busy", bus.busy, 1'b1);
    bus.vb = 1'b0;
    tick();
    vb_pulse();
    take_commit(4'd1, 4'd0);
    chk_active("same-edge");

    // New download starts on a vb rise while pending: cancel wins
    build(4'd0, 4'd1, 12'h777, 16'd0);
    send_q(-1, 1'b0, 1'b0);
    chk("cancel pending busy", bus.busy, 1'b1);
    bus.vb             = 1'b1;
    bus.ioctl_download = 1'b1;
    tick();
    bus.vb = 1'b0;
    chk("cancel no swap w", bus.active_w, 4'd1);
    chk("cancel no swap h", bus.active_h, 4'd0);
    chk("cancel busy parse", bus.busy, 1'b1);
    build(4'd3, 4'd3, 12'h888, 16'd0);
    send_q(-1, 1'b0, 1'b1);
    chk("second busy", bus.busy, 1'b1);
    chk("second no commit yet", bus.active_w, 4'd1);
    chk("second err_code", bus.err_code, 2'd0);
    vb_pulse();
    take_commit(4'd3, 4'd3);
    chk_active("second");

    // Reset mid-download
    build(4'd1, 4'd1, 12'h999, 16'd0);
    bus.ioctl_download = 1'b1;
    tick();
    wr_word(28'd0, q[0]);
    wr_word(28'd2, q[1]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.ioctl_download = 1'b0;
    tick();
    chk("midrst mask_valid", bus.mask_valid, 1'b0);
    chk("midrst busy", bus.busy, 1'b0);
    chk("midrst rd_data", bus.rd_data, 12'hFFF);
    vb_pulse();
    chk("midrst no commit", bus.mask_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
